// File: rtl/efb_wb_arbiter.sv
// efb_wb_arbiter: shares the single EFB Wishbone slave port between two
// requesters. Each request becomes one registered classic single cycle,
// ties are broken round-robin, and a stalled slave is abandoned after
// TIMEOUT_CYCLES bus cycles with an error completion.
//
// Requester handshake: a port raises i_ReqN with i_WeN/i_AddrN/i_WdataN
// stable and holds it until o_DoneN pulses for one cycle; o_ErrN qualifies
// that pulse (1 = timed out) and o_RdataN is refreshed only by a
// successful read on that port.
module efb_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Req0,
    input  logic       i_Req1,
    input  logic       i_We0,
    input  logic       i_We1,
    input  logic [7:0] i_Addr0,
    input  logic [7:0] i_Addr1,
    input  logic [7:0] i_Wdata0,
    input  logic [7:0] i_Wdata1,
    output logic       o_Done0,
    output logic       o_Done1,
    output logic       o_Err0,
    output logic       o_Err1,
    output logic [7:0] o_Rdata0,
    output logic [7:0] o_Rdata1,
    output logic       o_Busy,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          gnt_q, gnt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [7:0]    adr_q, adr_d;
    logic [7:0]    dat_q, dat_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err0_q, err0_d;
    logic          err1_q, err1_d;
    logic [7:0]    rdata0_q, rdata0_d;
    logic [7:0]    rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          pick;

    // Next-state and registered-output logic for the IDLE/BUS/GAP sequencer.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        cyc_d    = cyc_q;
        we_d     = we_q;
        adr_d    = adr_q;
        dat_d    = dat_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        pick     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_Req0 || i_Req1) begin
                    // On a tie the port not served last wins.
                    if (i_Req0 && i_Req1) pick = ~last_q;
                    else                  pick = i_Req1;
                    gnt_d   = pick;
                    we_d    = pick ? i_We1 : i_We0;
                    adr_d   = pick ? i_Addr1 : i_Addr0;
                    if (pick) dat_d = i_We1 ? i_Wdata1 : 8'h00;
                    else      dat_d = i_We0 ? i_Wdata0 : 8'h00;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (wb_ack_i) begin
                    cyc_d = 1'b0;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        if (!we_q) rdata1_d = wb_dat_i;
                    end else begin
                        done0_d = 1'b1;
                        if (!we_q) rdata0_d = wb_dat_i;
                    end
                    last_d  = gnt_q;
                    state_d = ST_GAP;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d = 1'b0;
                    if (gnt_q) begin
                        done1_d = 1'b1;
                        err1_d  = 1'b1;
                    end else begin
                        done0_d = 1'b1;
                        err0_d  = 1'b1;
                    end
                    last_d  = gnt_q;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                // One dead cycle so a requester can drop its request
                // after done without being granted again.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            cnt_q    <= '0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= 8'h00;
            dat_q    <= 8'h00;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= 8'h00;
            rdata1_q <= 8'h00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            cyc_q    <= cyc_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
        end
    end

    assign o_Done0  = done0_q;
    assign o_Done1  = done1_q;
    assign o_Err0   = err0_q;
    assign o_Err1   = err1_q;
    assign o_Rdata0 = rdata0_q;
    assign o_Rdata1 = rdata1_q;
    assign o_Busy   = busy_q;
    assign wb_cyc_o = cyc_q;
    assign wb_stb_o = cyc_q;
    assign wb_we_o  = we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;

endmodule

// File: doc/efb_wb_arbiter.md
# efb_wb_arbiter

Two-port Wishbone arbiter and transaction sequencer for the single EFB Wishbone slave port (timer/counter registers). It lets two internal requesters share the bus, for example the timer-count poller and the UART command path that writes timer configuration. Each request is converted into one registered Wishbone classic single cycle, with round-robin fairness and a bus timeout. It sits between the requesters in `top` and the EFB instance, clocked by the PLL output `Clock`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in BUS without `wb_ack_i` before abort. Legal range 1..255.

Ports:
- `i_Clock` in 1: system clock; all logic is on its rising edge.
- `i_Reset` in 1: reset, synchronous and active-high.
- `i_Req0` / `i_Req1` in 1: transaction request per port. Held high until that port's done pulse.
- `i_We0` / `i_We1` in 1: 1 = write, 0 = read. Stable while the request is high.
- `i_Addr0` / `i_Addr1` in 8: EFB register address. Stable while the request is high.
- `i_Wdata0` / `i_Wdata1` in 8: write data. Stable while the request is high.
- `o_Done0` / `o_Done1` out 1: one-cycle completion pulse.
- `o_Err0` / `o_Err1` out 1: high together with the done pulse if the transaction timed out.
- `o_Rdata0` / `o_Rdata1` out 8: read data. Updated only on a successful read completion for that port, held otherwise.
- `o_Busy` out 1: high in BUS and GAP states.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone master controls.
- `wb_adr_o` out 8, `wb_dat_o` out 8: Wishbone address and write data.
- `wb_dat_i` in 8, `wb_ack_i` in 1: Wishbone slave response.

## Operation
- States: IDLE, BUS, GAP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant that port.
  - If both are high, grant the port not served last. The `last` register resets to 1, so port 0 wins the first tie.
  - On grant, register `wb_we_o`, `wb_adr_o`, `wb_dat_o` (write data, or 8'h00 for reads) and the grant index. Set `wb_cyc_o = wb_stb_o = 1`, clear the timeout counter, go to BUS.
- BUS:
  - Master outputs are held constant.
  - If `wb_ack_i` = 1:
    - Drop cyc and stb.
    - For a read, capture `wb_dat_i` into `o_RdataN` of the granted port.
    - Pulse `o_DoneN` with `o_ErrN = 0`, set `last` to the granted port, go to GAP.
  - Else if the counter = TIMEOUT_CYCLES-1:
    - Drop cyc and stb.
    - Pulse `o_DoneN` with `o_ErrN = 1`; `o_RdataN` is unchanged.
    - Set `last` to the granted port, go to GAP.
  - Else increment the counter. The counter is $clog2(TIMEOUT_CYCLES+1) bits wide and never wraps.
- GAP:
  - Lasts one cycle and ignores all requests, so a requester can drop its request after the done pulse without being re-granted.
  - Clear done/err, go to IDLE.
- Boundary rules:
  - `wb_ack_i` outside BUS is ignored: no state change, no output change.
  - Ack and timeout in the same cycle: ack wins (success).
  - A request dropped by its requester mid-transaction has no effect. The transaction completes and done still pulses.
  - The ungranted port's request stays pending and is served next. Round-robin guarantees at most one transaction of wait.
  - The outputs of the ungranted port never change.

## Timing
- All outputs are registered. Reset value of every output is 0, including `o_RdataN`, `wb_adr_o` and `wb_dat_o`; state resets to IDLE and `last` to 1.
- Reset is sampled at the edge. If it is high mid-transaction, the next cycle has cyc/stb = 0 and no done/err pulse; the transaction is abandoned.
- Request to bus: a request high at edge E in IDLE gives `wb_cyc_o`/`wb_stb_o` = 1 from E+1.
- Completion: an ack sampled at edge Ea gives cyc/stb = 0, `o_DoneN` = 1 and valid `o_RdataN` from Ea+1, with done low again at Ea+2.
- Minimum request-to-done latency is 2 edges (ack in the first BUS cycle).
- Back-to-back: the next grant is sampled at Ea+2 and the bus is re-asserted at Ea+3, so there are two idle bus cycles between transactions.
- Timeout: with no ack, done/err rise exactly TIMEOUT_CYCLES+1 edges after the grant edge.

## Test plan
- Port 0 read of 8'h66, slave acks 3 cycles after stb with 8'hA5: `wb_adr_o` = 8'h66 and `wb_we_o` = 0 throughout, `o_Rdata0` = 8'hA5, single `o_Done0` pulse, `o_Err0` = 0, `o_Rdata1` unchanged (8'h00).
- Simultaneous requests, both held for 4 transactions each (port 0 write 8'h5E to 8'h5C; port 1 read of 8'h66): grants alternate 0,1,0,1,... starting with port 0, and no transaction overlaps.
- Port 0 re-requests immediately after each done while port 1 is waiting: port 1 is served next. Check the GAP cycle and the E+1 / Ea+1 latencies.
- No ack with TIMEOUT_CYCLES = 8: cyc/stb stay high for exactly 8 cycles; then `o_Done1` = `o_Err1` = 1 for one cycle; `o_Rdata1` keeps its previous value; the next request proceeds normally.
- `i_Reset` pulsed during BUS: next cycle all outputs are 0 and no done pulse occurs; after release, a pending request is granted to port 0.
- Stray `wb_ack_i` pulses in IDLE and GAP, and ack coinciding with the timeout cycle: stray acks cause no change; the coincident case completes with `o_Err` = 0 and captured data.
